// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register-index width, the hardwired zero register,
// and the default mult/div occupancy.
package pipeline_pkg;
   localparam int REG_IDX_W          = 5;
   localparam int MULDIV_LATENCY_DEF = 4;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: ID/EX hazard sources in, pipeline control strobes out.
// master = pipeline datapath side, slave = hazard controller.
interface hazard_ctrl_unit_if #(
   parameter int STALL_CNT_W = 16
);
   import pipeline_pkg::*;

   reg_idx_t               IFID_Rs;
   reg_idx_t               IFID_Rt;
   logic                   ID_UsesRt;
   logic                   IDEX_MemRead;
   reg_idx_t               IDEX_Rt;
   logic                   ID_BranchTaken;
   logic                   ID_Jump;
   logic                   ID_MulDivStart;
   logic                   ID_MulDivUse;
   logic                   PCWrite;
   logic                   IFID_WriteEnable;
   logic                   IFID_Flush;
   logic                   IDEX_Bubble;
   logic                   MulDiv_Busy;
   logic [STALL_CNT_W-1:0] Stall_Count;

   modport master (
      output IFID_Rs, IFID_Rt, ID_UsesRt, IDEX_MemRead, IDEX_Rt,
             ID_BranchTaken, ID_Jump, ID_MulDivStart, ID_MulDivUse,
      input  PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Bubble,
             MulDiv_Busy, Stall_Count
   );

   modport slave (
      input  IFID_Rs, IFID_Rt, ID_UsesRt, IDEX_MemRead, IDEX_Rt,
             ID_BranchTaken, ID_Jump, ID_MulDivStart, ID_MulDivUse,
      output PCWrite, IFID_WriteEnable, IFID_Flush, IDEX_Bubble,
             MulDiv_Busy, Stall_Count
   );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use compare between the load in EX and the source operands in ID.
// A load targeting the zero register can never create a dependency.
module load_use_detect
   import pipeline_pkg::*;
(
   input  reg_idx_t ifid_rs,
   input  reg_idx_t ifid_rt,
   input  logic     id_uses_rt,
   input  logic     idex_mem_read,
   input  reg_idx_t idex_rt,
   output logic     load_use
);
   assign load_use = idex_mem_read && (idex_rt != REG_ZERO) &&
                     ((idex_rt == ifid_rs) || (id_uses_rt && (idex_rt == ifid_rt)));
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use and mult/div stalls, redirect flush, stall counter.
// Control outputs are combinational (zero latency); only the busy and stall counters are state.
module hazard_ctrl_unit
   import pipeline_pkg::*;
#(
   parameter int MULDIV_LATENCY = MULDIV_LATENCY_DEF,
   parameter int STALL_CNT_W    = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   hazard_ctrl_unit_if.slave  bus
);
   localparam int                BUSY_W    = $clog2(MULDIV_LATENCY + 1);
   localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(MULDIV_LATENCY);

   logic [BUSY_W-1:0]      busy_cnt;
   logic [STALL_CNT_W-1:0] stall_cnt;
   logic                   load_use;
   logic                   muldiv_busy;
   logic                   md_stall;
   logic                   stall;
   logic                   redirect;

   load_use_detect u_load_use_detect (
      .ifid_rs       (bus.IFID_Rs),
      .ifid_rt       (bus.IFID_Rt),
      .id_uses_rt    (bus.ID_UsesRt),
      .idex_mem_read (bus.IDEX_MemRead),
      .idex_rt       (bus.IDEX_Rt),
      .load_use      (load_use)
   );

   assign muldiv_busy = (busy_cnt != '0);
   assign md_stall    = muldiv_busy && bus.ID_MulDivUse;
   assign stall       = load_use || md_stall;
   assign redirect    = bus.ID_BranchTaken || bus.ID_Jump;

   // Stall outranks redirect: the branch operands may still be in flight,
   // so the redirect is simply re-evaluated once the stall clears.
   assign bus.PCWrite          = !stall;
   assign bus.IFID_WriteEnable = !stall;
   assign bus.IDEX_Bubble      = stall;
   assign bus.IFID_Flush       = redirect && !stall;
   assign bus.MulDiv_Busy      = muldiv_busy;
   assign bus.Stall_Count      = stall_cnt;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         busy_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (bus.ID_MulDivStart && !stall) begin
            busy_cnt <= BUSY_LOAD;
         end else if (muldiv_busy) begin
            busy_cnt <= busy_cnt - BUSY_W'(1);
         end
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed vector table, hand sequences, and random
// stimulus against a cycle-stamp reference model; a second 3-bit instance covers saturation.
module tb_hazard_ctrl_unit;
   import pipeline_pkg::*;

   localparam int LAT     = 4;
   localparam int CNT_MAX = 65535;

   logic Clock;
   logic Reset;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   hazard_ctrl_unit_if #(.STALL_CNT_W(16)) hif ();
   hazard_ctrl_unit_if #(.STALL_CNT_W(3))  sif ();

   hazard_ctrl_unit #(.MULDIV_LATENCY(LAT), .STALL_CNT_W(16)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (hif)
   );

   hazard_ctrl_unit #(.MULDIV_LATENCY(LAT), .STALL_CNT_W(3)) dut_sat (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (sif)
   );

   typedef struct {
      logic [4:0] rs;
      logic [4:0] rt;
      logic       uses_rt;
      logic       mem_read;
      logic [4:0] ex_rt;
      logic       br;
      logic       jmp;
      logic       md_start;
      logic       md_use;
   } stim_t;

   typedef struct {
      stim_t s;
      int    bub;
      int    fl;
   } vec_t;

   int checks = 0;
   int errors = 0;
   // Model state: current cycle number, cycle of the last accepted mult/div, stall total.
   int cyc       = 0;
   int issue_cyc = -1000;
   int stalls    = 0;

   stim_t idle;
   vec_t  vecs[9];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input stim_t s);
      hif.IFID_Rs        = s.rs;
      hif.IFID_Rt        = s.rt;
      hif.ID_UsesRt      = s.uses_rt;
      hif.IDEX_MemRead   = s.mem_read;
      hif.IDEX_Rt        = s.ex_rt;
      hif.ID_BranchTaken = s.br;
      hif.ID_Jump        = s.jmp;
      hif.ID_MulDivStart = s.md_start;
      hif.ID_MulDivUse   = s.md_use;
   endtask

   task automatic model_reset();
      issue_cyc = -1000;
      stalls    = 0;
   endtask

   // Called at a negedge: applies one ID/EX snapshot, checks outputs against the
   // model (and optional hand-written expectations), then advances one clock.
   task automatic step(input stim_t s, input string tag, input int exp_bub = -1, input int exp_fl = -1);
      bit lu, busy, stall, flush;
      int exp_cnt;
      drive(s);
      #1;
      lu    = s.mem_read && (s.ex_rt != 0) &&
              ((s.ex_rt == s.rs) || (s.uses_rt && (s.ex_rt == s.rt)));
      busy  = (cyc > issue_cyc) && (cyc <= issue_cyc + LAT);
      stall = lu || (busy && s.md_use);
      flush = !stall && (s.br || s.jmp);
      exp_cnt = (stalls > CNT_MAX) ? CNT_MAX : stalls;
      chk({tag, ".pcwrite"}, int'(hif.PCWrite),          int'(!stall));
      chk({tag, ".ifid_we"}, int'(hif.IFID_WriteEnable), int'(!stall));
      chk({tag, ".bubble"},  int'(hif.IDEX_Bubble),      int'(stall));
      chk({tag, ".flush"},   int'(hif.IFID_Flush),       int'(flush));
      chk({tag, ".busy"},    int'(hif.MulDiv_Busy),      int'(busy));
      chk({tag, ".count"},   int'(hif.Stall_Count),      exp_cnt);
      if (exp_bub >= 0) begin
         chk({tag, ".hand_bubble"},  int'(hif.IDEX_Bubble), exp_bub);
         chk({tag, ".hand_pcwrite"}, int'(hif.PCWrite),     1 - exp_bub);
      end
      if (exp_fl >= 0) chk({tag, ".hand_flush"}, int'(hif.IFID_Flush), exp_fl);
      @(posedge Clock);
      if (stall) stalls++;
      if (s.md_start && !stall) issue_cyc = cyc;
      cyc++;
      @(negedge Clock);
   endtask

   initial begin
      stim_t s;
      idle = '{rs: 5'd0, rt: 5'd0, uses_rt: 1'b0, mem_read: 1'b0, ex_rt: 5'd0,
               br: 1'b0, jmp: 1'b0, md_start: 1'b0, md_use: 1'b0};

      //                rs     rt     uses  mrd   ex_rt  br    jmp   start use     bub fl
      vecs[0] = '{'{5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0};
      vecs[1] = '{'{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 0};
      vecs[2] = '{'{5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 0};
      vecs[3] = '{'{5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0}, 1, 0};
      vecs[4] = '{'{5'd8, 5'd8, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 0};
      vecs[5] = '{'{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0}, 0, 1};
      vecs[6] = '{'{5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0}, 1, 0};
      vecs[7] = '{'{5'd9, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0}, 0, 1};
      vecs[8] = '{'{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, 0, 0};

      sif.IFID_Rs = '0; sif.IFID_Rt = '0; sif.ID_UsesRt = 1'b0; sif.IDEX_MemRead = 1'b0;
      sif.IDEX_Rt = '0; sif.ID_BranchTaken = 1'b0; sif.ID_Jump = 1'b0;
      sif.ID_MulDivStart = 1'b0; sif.ID_MulDivUse = 1'b0;

      // Reset held with random inputs, then released with idle inputs.
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s.rs = 5'($urandom_range(0, 31)); s.rt = 5'($urandom_range(0, 31));
         s.uses_rt = 1'($urandom); s.mem_read = 1'($urandom); s.ex_rt = 5'($urandom_range(0, 31));
         s.br = 1'($urandom); s.jmp = 1'($urandom); s.md_start = 1'($urandom); s.md_use = 1'($urandom);
         drive(s);
         @(negedge Clock);
         chk("rst_hold.busy",  int'(hif.MulDiv_Busy), 0);
         chk("rst_hold.count", int'(hif.Stall_Count), 0);
      end
      drive(idle);
      Reset = 1'b1;
      #1;
      chk("rst.pcwrite", int'(hif.PCWrite),          1);
      chk("rst.ifid_we", int'(hif.IFID_WriteEnable), 1);
      chk("rst.flush",   int'(hif.IFID_Flush),       0);
      chk("rst.bubble",  int'(hif.IDEX_Bubble),      0);
      chk("rst.busy",    int'(hif.MulDiv_Busy),      0);
      chk("rst.count",   int'(hif.Stall_Count),      0);
      model_reset();
      @(negedge Clock);

      for (int i = 0; i < 9; i++) begin
         step(vecs[i].s, $sformatf("vec%0d", i), vecs[i].bub, vecs[i].fl);
      end
      chk("vec.count_total", int'(hif.Stall_Count), 3);

      // mult at t, mfhi from t+1: four stall cycles, proceeds at t+5.
      s = idle; s.md_start = 1'b1; s.md_use = 1'b1;
      step(s, "md_issue", 0, 0);
      s = idle; s.md_use = 1'b1;
      for (int k = 1; k <= LAT + 1; k++) begin
         step(s, $sformatf("md_dep%0d", k), (k <= LAT) ? 1 : 0, 0);
      end
      chk("md.count_total", int'(hif.Stall_Count), 7);

      // Independent instruction right behind a mult proceeds while busy.
      s = idle; s.md_start = 1'b1; s.md_use = 1'b1;
      step(s, "md_issue2", 0, 0);
      s = idle; s.rs = 5'd4; s.rt = 5'd5; s.uses_rt = 1'b1;
      drive(s);
      #1;
      chk("md_add.busy_hand", int'(hif.MulDiv_Busy), 1);
      step(s, "md_add", 0, 0);
      for (int k = 0; k < LAT; k++) step(idle, "md_drain");

      for (int i = 0; i < 400; i++) begin
         s.rs       = 5'($urandom_range(0, 3));
         s.rt       = 5'($urandom_range(0, 3));
         s.uses_rt  = 1'($urandom);
         s.mem_read = 1'($urandom);
         s.ex_rt    = 5'($urandom_range(0, 3));
         s.br       = ($urandom_range(0, 5) == 0);
         s.jmp      = ($urandom_range(0, 7) == 0);
         s.md_start = ($urandom_range(0, 7) == 0);
         s.md_use   = s.md_start || ($urandom_range(0, 2) == 0);
         step(s, "rand");
      end

      // Reset two cycles into a mult: busy and count clear at once.
      s = idle; s.md_start = 1'b1; s.md_use = 1'b1;
      step(s, "mb_issue");
      step(idle, "mb_t1");
      drive(idle);
      Reset = 1'b0;
      #1;
      chk("mb_rst.busy",  int'(hif.MulDiv_Busy), 0);
      chk("mb_rst.count", int'(hif.Stall_Count), 0);
      model_reset();
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      s = idle; s.md_use = 1'b1;
      step(s, "mb_mfhi", 0, 0);

      // Narrow counter: ten back-to-back load-use stalls hold at 7.
      sif.IDEX_MemRead = 1'b1;
      sif.IDEX_Rt      = 5'd8;
      sif.IFID_Rs      = 5'd8;
      for (int k = 1; k <= 10; k++) begin
         @(posedge Clock);
         @(negedge Clock);
         chk($sformatf("sat.count%0d", k), int'(sif.Stall_Count), (k > 7) ? 7 : k);
      end
      chk("sat.bubble", int'(sif.IDEX_Bubble), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage MIPS core. It generates the IF/ID register's `WriteEnable` and `Flush`, the PC write enable, and the ID/EX bubble.
- Detects load-use hazards, which cost a 1-cycle stall.
- Applies branch/jump redirect flushes.
- Sequences a multi-cycle mult/div unit with an internal busy counter.
- Keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `MULDIV_LATENCY`, default 4: EX cycles a mult/div occupies after issue, excluding the issue cycle. Legal range is ≥1.
- `STALL_CNT_W`, default 16: width of the stall performance counter.

Ports:
- `Clock` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-low reset (asserted when 0).
- `IFID_Rs` in 5: rs field of the instruction in ID.
- `IFID_Rt` in 5: rt field of the instruction in ID.
- `ID_UsesRt` in 1: ID instruction reads rt as a source.
- `IDEX_MemRead` in 1: instruction in EX is a load.
- `IDEX_Rt` in 5: destination of that load.
- `ID_BranchTaken` in 1: branch resolved taken in ID.
- `ID_Jump` in 1: j/jal/jr in ID.
- `ID_MulDivStart` in 1: ID instruction is mult/multu/div/divu.
- `ID_MulDivUse` in 1: ID instruction needs the mult/div unit (mfhi, mflo, or any mult/div).
- `PCWrite` out 1: PC register update enable.
- `IFID_WriteEnable` out 1: IF/ID register load enable.
- `IFID_Flush` out 1: zero the IF/ID register.
- `IDEX_Bubble` out 1: load a NOP into ID/EX.
- `MulDiv_Busy` out 1: mult/div unit occupied.
- `Stall_Count` out `STALL_CNT_W`: saturating count of stall cycles.

## Operation
Load-use hazard:
- `LoadUse = IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || (ID_UsesRt && IDEX_Rt == IFID_Rt))`.

Mult/div busy tracking:
- `BusyCnt` is a `$clog2(MULDIV_LATENCY+1)`-bit register.
- `MulDiv_Busy = (BusyCnt != 0)`.
- `MDStall = MulDiv_Busy && ID_MulDivUse`.

Stall:
- `Stall = LoadUse || MDStall`.
- While `Stall` is 1: `PCWrite=0`, `IFID_WriteEnable=0`, `IDEX_Bubble=1`, `IFID_Flush=0`.

Redirect:
- `Redirect = ID_BranchTaken || ID_Jump`.
- When `Redirect` is 1 and `Stall` is 0: `IFID_Flush=1` and `PCWrite=1`.
- Stall takes priority, because ID operands or hazards are unresolved. The redirect is re-evaluated the next cycle.

Issue:
- When `ID_MulDivStart` is 1 and `Stall` is 0, then at the clock edge `BusyCnt <= MULDIV_LATENCY`.
- Otherwise, if `BusyCnt != 0`, `BusyCnt` decrements by 1.
- A second mult/div cannot issue while busy, because it asserts `ID_MulDivUse` and therefore stalls.

Other rules:
- A non-mult/div instruction proceeds normally while `MulDiv_Busy` is 1.
- `Stall_Count` increments on every cycle where `Stall` is 1 and saturates at all-ones; it never wraps.
- `IDEX_Rt == 0` never causes a hazard.

Simultaneous events:
- `LoadUse` and `MDStall` together: a single stall cycle is counted once.
- Redirect plus stall: stall wins, as above.

Reset (`Reset` = 0, at any time, including mid-busy):
- `BusyCnt=0` and `Stall_Count=0` immediately.
- With idle inputs, outputs then settle to: `PCWrite=1`, `IFID_WriteEnable=1`, `IFID_Flush=0`, `IDEX_Bubble=0`, `MulDiv_Busy=0`.

## Timing
- All control outputs are combinational from the current inputs and registered state. The pipeline registers sample them on the same edge; there is zero-cycle latency.
- A load-use stall lasts exactly 1 cycle, because the next cycle EX holds a bubble with `IDEX_MemRead=0`.
- Mult/div issued at cycle t:
  - `MulDiv_Busy` is 1 for cycles t+1 through t+`MULDIV_LATENCY`.
  - A dependent instruction in ID at t+1 stalls `MULDIV_LATENCY` cycles and proceeds at t+`MULDIV_LATENCY`+1.
- Redirect flush is 1 cycle, which squashes the single fetched delay slot.
- Reset deassertion is synchronous to `Clock` at the system level. The first active edge after release behaves as normal operation.

## Structure
- Shared package `pipeline_pkg`:
  - `REG_ZERO` (5'd0).
  - Register-index width constant (5).
  - Default `MULDIV_LATENCY`.
- Sub-module `load_use_detect`: purely combinational hazard compare, reused by the forwarding unit's tests. The busy counter, stall counter and output logic stay in the top module.

## Test plan
- Reset: hold `Reset`=0 with random inputs, then release. Required: `PCWrite=1`, `IFID_WriteEnable=1`, flushes 0, `MulDiv_Busy=0`, `Stall_Count=0`.
- Load-use: `IDEX_MemRead=1`, `IDEX_Rt=8`, `IFID_Rs=8` for 1 cycle. Required: `PCWrite=0`, `IFID_WriteEnable=0`, `IDEX_Bubble=1` for 1 cycle; `Stall_Count=1`. Repeat with `IDEX_Rt=0`, and with rt match but `ID_UsesRt=0`: no stall in either case.
- Mult/div dependency (`MULDIV_LATENCY`=4):
  - Issue mult at t, then present mfhi in ID from t+1. Required: stall at t+1 through t+4, proceed at t+5, `Stall_Count=4`.
  - An independent add at t+1 does not stall.
- Redirect vs stall:
  - `ID_Jump=1` alone gives `IFID_Flush=1` for 1 cycle.
  - `ID_BranchTaken=1` with `LoadUse` gives `IFID_Flush=0` plus stall, then the next cycle `IFID_Flush=1`.
- Reset mid-busy: assert `Reset` at t+2 after a mult issue. Required: `MulDiv_Busy=0` immediately; a dependent mfhi after release does not stall.
- Saturation: `STALL_CNT_W`=3, force 10 consecutive stall cycles. Required: `Stall_Count` holds at 7.
